// File: rtl/planificador_pisos.sv
// planificador_pisos: elevator floor scheduler.
// Latches floor calls, tracks the current floor from a one-hot position
// sensor and commands the elevator controller with a SCAN-style policy:
// keep moving while requests remain ahead, stop at each requested floor
// for T_LLEGADA cycles, and only reverse direction after a stop.
module planificador_pisos #(
    parameter int N_PISOS   = 4,
    parameter int T_LLEGADA = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PISOS-1:0] boton_piso,
    input  logic [N_PISOS-1:0] sensor_piso,
    output logic [1:0]         accion,
    output logic [2:0]         piso_actual,
    output logic [N_PISOS-1:0] pendientes,
    output logic               error_sensor
);

    // State codes double as the accion command, so accion is the state
    // register itself: registered and with no decode latency.
    typedef enum logic [1:0] {
        INACTIVO = 2'b00,
        LLEGADA  = 2'b01,
        SUBIR    = 2'b10,
        BAJAR    = 2'b11
    } estado_t;

    // The stop counter is loaded with T_LLEGADA-1 and LLEGADA is left on the
    // cycle it reads zero, which gives exactly T_LLEGADA cycles at a floor.
    localparam logic [7:0] CARGA_LLEGADA = 8'(T_LLEGADA - 1);

    estado_t            estado, estado_d;
    logic               dir_prev, dir_prev_d;
    logic [7:0]         contador, contador_d;
    logic [2:0]         piso_d;
    logic [N_PISOS-1:0] pendientes_d;
    logic               error_d;

    logic [3:0]         n_activos;
    logic [2:0]         indice_sensor;
    logic               sensor_valido;
    logic               sensor_multiple;

    logic               hay_arriba;
    logic               hay_abajo;
    logic               hay_aqui;
    logic               pend_en_sensor;
    logic               llega_nuevo;
    logic [N_PISOS-1:0] limpiar;

    // Sensor decode: count active bits and remember the index of the active one.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        n_activos     = 4'd0;
        indice_sensor = 3'd0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (sensor_piso[i]) begin
                n_activos     = n_activos + 4'd1;
                indice_sensor = 3'(i);
            end
        end
    end

    assign sensor_valido   = (n_activos == 4'd1);
    assign sensor_multiple = (n_activos > 4'd1);
    assign piso_d          = sensor_valido ? indice_sensor : piso_actual;
    assign error_d         = error_sensor | sensor_multiple;

    // Request masks relative to the current floor, plus the request bit at
    // the floor the sensor is reporting right now.
    always_comb begin
        hay_arriba     = 1'b0;
        hay_abajo      = 1'b0;
        hay_aqui       = 1'b0;
        pend_en_sensor = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (3'(i) > piso_actual) begin
                hay_arriba = hay_arriba | pendientes[i];
            end
            if (3'(i) < piso_actual) begin
                hay_abajo = hay_abajo | pendientes[i];
            end
            if (3'(i) == piso_actual) begin
                hay_aqui = hay_aqui | pendientes[i];
            end
            if (3'(i) == indice_sensor) begin
                pend_en_sensor = pend_en_sensor | pendientes[i];
            end
        end
    end

    // Arrival at a new, requested floor is judged on the same edge that
    // piso_actual takes that floor.
    assign llega_nuevo = sensor_valido && (indice_sensor != piso_actual) && pend_en_sensor;

    // Next-state, direction memory and stop counter.
    always_comb begin
        estado_d   = estado;
        dir_prev_d = dir_prev;
        contador_d = (contador != 8'd0) ? contador - 8'd1 : 8'd0;

        case (estado)
            INACTIVO: begin
                if (hay_aqui) begin
                    estado_d = LLEGADA;
                end else if (hay_arriba) begin
                    estado_d = SUBIR;
                end else if (hay_abajo) begin
                    estado_d = BAJAR;
                end
            end

            SUBIR: begin
                // Stop at a requested floor, or at the current floor once
                // nothing is left above.
                if (llega_nuevo || !hay_arriba) begin
                    estado_d   = LLEGADA;
                    dir_prev_d = 1'b0;
                end
            end

            BAJAR: begin
                if (llega_nuevo || !hay_abajo) begin
                    estado_d   = LLEGADA;
                    dir_prev_d = 1'b1;
                end
            end

            LLEGADA: begin
                if (contador == 8'd0) begin
                    if (dir_prev ? hay_abajo : hay_arriba) begin
                        estado_d = dir_prev ? BAJAR : SUBIR;
                    end else if (dir_prev ? hay_arriba : hay_abajo) begin
                        estado_d = dir_prev ? SUBIR : BAJAR;
                    end else if (hay_aqui) begin
                        estado_d = LLEGADA;
                    end else begin
                        estado_d = INACTIVO;
                    end
                end
            end

            default: estado_d = INACTIVO;
        endcase

        // Fresh entry into LLEGADA, or a repeated stop, reloads the counter.
        if ((estado_d == LLEGADA) && ((estado != LLEGADA) || (contador == 8'd0))) begin
            contador_d = CARGA_LLEGADA;
        end
    end

    // Request latch: while stopped (or on the stopping edge) the request of
    // the floor we are at is cleared, and the clear beats a simultaneous press.
    always_comb begin
        limpiar = '0;
        if (estado_d == LLEGADA) begin
            for (int i = 0; i < N_PISOS; i++) begin
                if (3'(i) == piso_d) begin
                    limpiar[i] = 1'b1;
                end
            end
        end
        pendientes_d = (pendientes | boton_piso) & ~limpiar;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado       <= INACTIVO;
            dir_prev     <= 1'b0;
            contador     <= 8'd0;
            piso_actual  <= 3'd0;
            pendientes   <= '0;
            error_sensor <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values of the previous cycle regardless of statement order.
            estado       <= estado_d;
            dir_prev     <= dir_prev_d;
            contador     <= contador_d;
            piso_actual  <= piso_d;
            pendientes   <= pendientes_d;
            error_sensor <= error_d;
        end
    end

    assign accion = estado;

endmodule

// File: tb/tb_planificador_pisos.sv
// Self-checking bench for planificador_pisos (4 floors, 4-cycle stops):
// a table of directed vectors with fixed expectations, hand sequences for
// scan order and asynchronous reset, and a random run against a
// rule-level reference model.
module tb_planificador_pisos;

    localparam int N = 4;
    localparam int T = 4;

    localparam int A_IDLE = 0;
    localparam int A_LLEG = 1;
    localparam int A_UP   = 2;
    localparam int A_DOWN = 3;

    logic         clk;
    logic         reset;
    logic [N-1:0] boton_piso;
    logic [N-1:0] sensor_piso;
    logic [1:0]   accion;
    logic [2:0]   piso_actual;
    logic [N-1:0] pendientes;
    logic         error_sensor;

    planificador_pisos #(
        .N_PISOS   (N),
        .T_LLEGADA (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .boton_piso   (boton_piso),
        .sensor_piso  (sensor_piso),
        .accion       (accion),
        .piso_actual  (piso_actual),
        .pendientes   (pendientes),
        .error_sensor (error_sensor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nombre, actual, esperado, $time);
        end
    endtask

    // Reference model: current command, floor, requests, stop time left,
    // last travel direction (1 = down) and sticky sensor error.
    int       m_acc, m_piso, m_rest;
    bit       m_dir, m_err;
    bit [N-1:0] m_pend;
    int       n_acc, n_piso, n_rest;
    bit       n_dir, n_err;
    bit [N-1:0] n_pend;

    int llegadas[$];

    task automatic modelo_reset();
        m_acc  = A_IDLE;
        m_piso = 0;
        m_rest = 0;
        m_dir  = 1'b0;
        m_err  = 1'b0;
        m_pend = '0;
    endtask

    // Compute the model's next cycle from its current state and the inputs.
    task automatic modelo_calcular();
        int unos;
        int idx;
        bit arriba;
        bit abajo;
        bit seguir;
        bit volver;
        unos = 0;
        idx  = 0;
        for (int i = 0; i < N; i++) begin
            if (sensor_piso[i]) begin
                unos++;
                idx = i;
            end
        end
        n_piso = (unos == 1) ? idx : m_piso;
        n_err  = m_err || (unos > 1);

        arriba = 1'b0;
        abajo  = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (m_pend[j] && j > m_piso) arriba = 1'b1;
            if (m_pend[j] && j < m_piso) abajo  = 1'b1;
        end

        n_acc  = m_acc;
        n_dir  = m_dir;
        n_rest = m_rest;
        case (m_acc)
            A_IDLE: begin
                if (m_pend[m_piso])  n_acc = A_LLEG;
                else if (arriba)     n_acc = A_UP;
                else if (abajo)      n_acc = A_DOWN;
                if (n_acc == A_LLEG) n_rest = T;
            end
            A_UP, A_DOWN: begin
                if ((n_piso != m_piso && m_pend[n_piso]) ||
                    (m_acc == A_UP ? !arriba : !abajo)) begin
                    n_acc  = A_LLEG;
                    n_dir  = (m_acc == A_DOWN);
                    n_rest = T;
                end
            end
            default: begin
                if (m_rest > 1) begin
                    n_rest = m_rest - 1;
                end else begin
                    seguir = m_dir ? abajo : arriba;
                    volver = m_dir ? arriba : abajo;
                    if (seguir)               n_acc = m_dir ? A_DOWN : A_UP;
                    else if (volver)          n_acc = m_dir ? A_UP : A_DOWN;
                    else if (m_pend[m_piso])  n_rest = T;
                    else                      n_acc = A_IDLE;
                end
            end
        endcase

        n_pend = m_pend | boton_piso;
        if (n_acc == A_LLEG) n_pend[n_piso] = 1'b0;
    endtask

    // One clock: advance the model, let the DUT take the edge, compare #1 later.
    task automatic ciclo();
        int acc_prev;
        modelo_calcular();
        acc_prev = int'(accion);
        @(posedge clk);
        #1;
        m_acc  = n_acc;
        m_piso = n_piso;
        m_rest = n_rest;
        m_dir  = n_dir;
        m_err  = n_err;
        m_pend = n_pend;
        check("modelo_accion", 32'(accion), 32'(m_acc));
        check("modelo_piso", 32'(piso_actual), 32'(m_piso));
        check("modelo_pendientes", 32'(pendientes), 32'(m_pend));
        check("modelo_error", 32'(error_sensor), 32'(m_err));
        check("reversa_directa",
              32'((acc_prev >= 2) && (int'(accion) >= 2) && (acc_prev != int'(accion))), 32'd0);
        if (accion == 2'b01 && acc_prev != 1) llegadas.push_back(int'(piso_actual));
    endtask

    // Assert reset between edges, check outputs clear before any edge,
    // release just after a rising edge.
    task automatic aplicar_reset();
        #3;
        reset = 1'b0;
        #2;
        check("reset_accion", 32'(accion), 32'd0);
        check("reset_pendientes", 32'(pendientes), 32'd0);
        check("reset_piso", 32'(piso_actual), 32'd0);
        check("reset_error", 32'(error_sensor), 32'd0);
        modelo_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] boton;
        logic [N-1:0] sensor;
        logic [1:0]   acc;
        logic [N-1:0] pend;
        logic [2:0]   piso;
        logic         err;
    } vec_t;

    vec_t tabla[28];

    initial begin
        // boton, sensor -> accion, pendientes, piso_actual, error_sensor after the edge
        tabla[0]  = '{4'b0000, 4'b0001, 2'b00, 4'b0000, 3'd0, 1'b0};
        tabla[1]  = '{4'b0100, 4'b0001, 2'b00, 4'b0100, 3'd0, 1'b0};
        tabla[2]  = '{4'b0000, 4'b0001, 2'b10, 4'b0100, 3'd0, 1'b0};
        tabla[3]  = '{4'b0000, 4'b0000, 2'b10, 4'b0100, 3'd0, 1'b0};
        tabla[4]  = '{4'b0000, 4'b0010, 2'b10, 4'b0100, 3'd1, 1'b0};
        tabla[5]  = '{4'b0000, 4'b0000, 2'b10, 4'b0100, 3'd1, 1'b0};
        tabla[6]  = '{4'b0000, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[7]  = '{4'b0100, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[8]  = '{4'b0000, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[9]  = '{4'b0000, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[10] = '{4'b0000, 4'b0100, 2'b00, 4'b0000, 3'd2, 1'b0};
        tabla[11] = '{4'b0000, 4'b0100, 2'b00, 4'b0000, 3'd2, 1'b0};
        tabla[12] = '{4'b0100, 4'b0100, 2'b00, 4'b0100, 3'd2, 1'b0};
        tabla[13] = '{4'b0000, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[14] = '{4'b0100, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[15] = '{4'b0000, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[16] = '{4'b0000, 4'b0100, 2'b01, 4'b0000, 3'd2, 1'b0};
        tabla[17] = '{4'b0000, 4'b0100, 2'b00, 4'b0000, 3'd2, 1'b0};
        tabla[18] = '{4'b0000, 4'b0110, 2'b00, 4'b0000, 3'd2, 1'b1};
        tabla[19] = '{4'b0000, 4'b0100, 2'b00, 4'b0000, 3'd2, 1'b1};
        tabla[20] = '{4'b0001, 4'b0100, 2'b00, 4'b0001, 3'd2, 1'b1};
        tabla[21] = '{4'b0000, 4'b0100, 2'b11, 4'b0001, 3'd2, 1'b1};
        tabla[22] = '{4'b0000, 4'b0010, 2'b11, 4'b0001, 3'd1, 1'b1};
        tabla[23] = '{4'b0000, 4'b0001, 2'b01, 4'b0000, 3'd0, 1'b1};
        tabla[24] = '{4'b1000, 4'b0001, 2'b01, 4'b1000, 3'd0, 1'b1};
        tabla[25] = '{4'b0000, 4'b0001, 2'b01, 4'b1000, 3'd0, 1'b1};
        tabla[26] = '{4'b0000, 4'b0001, 2'b01, 4'b1000, 3'd0, 1'b1};
        tabla[27] = '{4'b0000, 4'b0001, 2'b10, 4'b1000, 3'd0, 1'b1};

        // Power-up reset with the car parked at floor 0.
        reset       = 1'b0;
        boton_piso  = '0;
        sensor_piso = 4'b0001;
        modelo_reset();
        #2;
        check("reset_inicial_accion", 32'(accion), 32'd0);
        check("reset_inicial_pendientes", 32'(pendientes), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle: nothing pressed for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            ciclo();
            check("inactivo_accion", 32'(accion), 32'd0);
            check("inactivo_pendientes", 32'(pendientes), 32'd0);
        end

        // Directed vectors: up trip, same-floor call, sensor fault, down trip, reversal.
        for (int i = 0; i < 28; i++) begin
            boton_piso  = tabla[i].boton;
            sensor_piso = tabla[i].sensor;
            ciclo();
            check($sformatf("vec%0d_accion", i), 32'(accion), 32'(tabla[i].acc));
            check($sformatf("vec%0d_pendientes", i), 32'(pendientes), 32'(tabla[i].pend));
            check($sformatf("vec%0d_piso", i), 32'(piso_actual), 32'(tabla[i].piso));
            check($sformatf("vec%0d_error", i), 32'(error_sensor), 32'(tabla[i].err));
        end
        boton_piso = '0;

        // Scan order: moving up from floor 1 with calls at 3 and 0 -> stop at 3, then 0.
        aplicar_reset();
        llegadas.delete();
        sensor_piso = 4'b0001; boton_piso = 4'b1000; ciclo();
        boton_piso  = 4'b0000; ciclo();
        sensor_piso = 4'b0010; ciclo();
        boton_piso  = 4'b0001; ciclo();
        check("scan_pendientes", 32'(pendientes), 32'b1001);
        check("scan_subiendo", 32'(accion), 32'b10);
        boton_piso  = 4'b0000;
        sensor_piso = 4'b0100; ciclo();
        sensor_piso = 4'b1000; ciclo();
        for (int i = 0; i < T; i++) ciclo();
        check("scan_baja_tras_parada", 32'(accion), 32'b11);
        sensor_piso = 4'b0100; ciclo();
        sensor_piso = 4'b0010; ciclo();
        sensor_piso = 4'b0001; ciclo();
        check("scan_num_paradas", 32'(llegadas.size()), 32'd2);
        if (llegadas.size() == 2) begin
            check("scan_primera_parada", 32'(llegadas[0]), 32'd3);
            check("scan_segunda_parada", 32'(llegadas[1]), 32'd0);
        end
        for (int i = 0; i < T + 2; i++) ciclo();

        // Reset mid-travel with requests at 2 and 3 outstanding.
        aplicar_reset();
        sensor_piso = 4'b0001; boton_piso = 4'b1100; ciclo();
        boton_piso  = 4'b0000; ciclo();
        sensor_piso = 4'b0010; ciclo();
        check("pre_reset_accion", 32'(accion), 32'b10);
        check("pre_reset_pendientes", 32'(pendientes), 32'b1100);
        aplicar_reset();
        ciclo();
        check("post_reset_accion", 32'(accion), 32'd0);

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(0, 399) == 0) aplicar_reset();
            r = int'($urandom_range(0, 99));
            if (r < 15)       sensor_piso = 4'b0000;
            else if (r < 30)  sensor_piso = 4'b0001 << $urandom_range(0, N - 1);
            else if (r == 99) sensor_piso = 4'($urandom_range(3, 15)) | 4'b0011;
            boton_piso = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            ciclo();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/planificador_pisos.md
PLANIFICADOR_PISOS -- requirements
Module: planificador_pisos

Interface
REQ-001 The block SHALL have parameter N_PISOS, default 4, meaning the number of served floors (2..8).
REQ-002 The block SHALL have parameter T_LLEGADA, default 4, meaning the number of cycles accion is held at 2'b01 per stop (1..255).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; ports: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port boton_piso  input  N_PISOS  call buttons, level, bit i = floor i.
REQ-005 The block SHALL have port sensor_piso  input  N_PISOS  floor position sensor, one-hot at a floor, all-zero between floors.
REQ-006 The block SHALL have port accion  output  2  command to the elevator controller: 00 idle, 01 arrived at destination, 10 up, 11 down.
REQ-007 The block SHALL have port piso_actual  output  3  index of last valid floor seen.
REQ-008 The block SHALL have port pendientes  output  N_PISOS  latched outstanding requests.
REQ-009 The block SHALL have port error_sensor  output  1  sticky flag, multi-hot sensor_piso seen.

Function
REQ-010 All outputs SHALL be registered; accion SHALL be decoded from the current state register with no extra cycle of latency.
REQ-011 pendientes[i] SHALL be set at the clock edge where boton_piso[i]=1 and SHALL hold until cleared by REQ-016.
REQ-012 piso_actual SHALL load the index of sensor_piso when exactly one bit is set; all-zero SHALL hold the value; multi-hot SHALL hold the value and set error_sensor.
REQ-013 The state machine SHALL have states INACTIVO (accion 00), SUBIR (10), BAJAR (11), LLEGADA (01), plus a 1-bit register dir_prev (0 up, 1 down).
REQ-014 INACTIVO: pendientes[piso_actual]=1 -> LLEGADA; else any pending above piso_actual -> SUBIR; else any pending below -> BAJAR; else stay.
REQ-015 SUBIR/BAJAR: on the edge where piso_actual takes a new value whose pendientes bit is set -> LLEGADA; if no pending remains beyond piso_actual in the current direction -> LLEGADA (safety stop at current floor); dir_prev SHALL record the direction on exit.
REQ-016 On entry to LLEGADA, pendientes[piso_actual] SHALL be cleared; while in LLEGADA, a press of the button for piso_actual SHALL be ignored (clear wins over set); presses for other floors SHALL latch normally.
REQ-017 LLEGADA SHALL last exactly T_LLEGADA cycles using an 8-bit down-counter loaded on entry.
REQ-018 LLEGADA exit: pending in dir_prev direction -> that direction's state; else pending in opposite direction -> opposite state; else pending at piso_actual -> LLEGADA again (counter reloaded); else INACTIVO.
REQ-019 Direction SHALL never change from SUBIR directly to BAJAR or vice versa; every reversal SHALL pass through LLEGADA.
REQ-020 Counter arithmetic SHALL be unsigned and SHALL not wrap: counter stops at 0.
REQ-021 "Above"/"below" SHALL be computed as OR-reductions of pendientes masked by floor index relative to piso_actual, within the same cycle.

Reset
REQ-022 On reset low, asynchronously: state=INACTIVO, accion=00, pendientes=0, piso_actual=0, error_sensor=0, dir_prev=0, counter=0.
REQ-023 Reset asserted mid-LLEGADA or mid-travel SHALL discard all pending requests; after release the block SHALL behave as from power-up.
REQ-024 The first rising edge after reset release SHALL already sample boton_piso and sensor_piso.

Verification
REQ-025 Idle: reset, no buttons, sensor_piso=0001 for 20 cycles -> accion=00, pendientes=0000 throughout.
REQ-026 Up trip: at floor 0, pulse boton_piso=0100 -> next cycle accion=10; drive sensor 0010 then 0100 -> accion=01 from the edge sensor reads 0100, for exactly 4 cycles, pendientes[2] cleared, then accion=00.
REQ-027 Scan order: at floor 1 moving up with pendientes=1001 -> stops at floor 3 first, then accion=11, stops at floor 0; no 10->11 transition without intervening 01.
REQ-028 Same-floor call: idle at floor 2, press boton_piso[2] -> accion=01 for 4 cycles, re-pressing during LLEGADA leaves pendientes[2]=0.
REQ-029 Sensor fault: drive sensor_piso=0110 -> error_sensor=1, piso_actual unchanged; stays 1 until reset.
REQ-030 Reset mid-operation: assert reset during SUBIR with pendientes=1100 -> accion=00, pendientes=0000 immediately, without waiting for a clock edge.
